// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light command path: command types, sync
// pattern, error causes, assembler states and the payload-length rule.
package traffic_pkg;

    typedef enum logic [2:0] {
        CMD_RUN     = 3'd0,
        CMD_OFF     = 3'd1,
        CMD_BLINK_Y = 3'd2,
        CMD_SET_G   = 3'd3,
        CMD_SET_R   = 3'd4,
        CMD_SET_Y   = 3'd5
    } cmd_type_e;

    localparam logic [2:0] SYNC = 3'b101;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_SYNC     = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_CHECKSUM = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA_LO = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_CHECK   = 3'd3,
        ST_EMIT    = 3'd4
    } asm_state_e;

    // SET_G, SET_R and SET_Y carry a 16-bit payload; every other type is header-only.
    function automatic logic has_payload(input logic [2:0] cmd_type);
        return (cmd_type >= 3'd3) && (cmd_type <= 3'd5);
    endfunction

endpackage

// File: rtl/traffic_cmd_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT_CLK-th idle cycle is reached.
module traffic_cmd_timeout #(
    parameter int TIMEOUT_CLK = 2000
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CLK);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLK - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expire_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_cmd_assembler.sv
// Byte-stream to command assembler for the traffic light controller.
// Optional trailing XOR checksum byte is enabled by TRAFFIC_CMD_CHECKSUM_EN.
module traffic_cmd_assembler #(
    parameter int TIMEOUT_CLK = 2000,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic [7:0]           byte_data_i,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    output logic [2:0]           cmd_type_o,
    output logic [15:0]          cmd_data_o,
    output logic                 cmd_valid_o,
    output logic                 frame_err_o,
    output logic [1:0]           err_code_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);
    import traffic_pkg::*;

    asm_state_e           state_q;
    logic [2:0]           type_q;
    logic [7:0]           data_lo_q;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
    logic [7:0]           data_hi_q;
    logic [7:0]           csum_q;
`endif
    logic                 cmd_valid_q;
    logic [2:0]           cmd_type_q;
    logic [15:0]          cmd_data_q;
    logic                 frame_err_q;
    err_code_e            err_code_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic      accept;
    logic      in_frame;
    logic      tmo_expire;
    logic      tmo_hit;
    logic      err_set;
    err_code_e err_cause;

    // A byte moves on valid && ready; the only stall is the single EMIT cycle.
    assign byte_ready_o = (state_q != ST_EMIT);
    assign accept       = byte_valid_i && byte_ready_o;
    assign in_frame     = (state_q == ST_DATA_LO) || (state_q == ST_DATA_HI) ||
                          (state_q == ST_CHECK);
    assign tmo_hit      = tmo_expire && !accept;

    traffic_cmd_timeout #(
        .TIMEOUT_CLK(TIMEOUT_CLK)
    ) u_timeout (
        .clk_i   (clk_i),
        .arst_n_i(arst_n_i),
        .clear_i (accept || !in_frame),
        .enable_i(in_frame),
        .expire_o(tmo_expire)
    );

    always_comb begin
        err_set   = 1'b0;
        err_cause = ERR_NONE;
        if (tmo_hit) begin
            err_set   = 1'b1;
            err_cause = ERR_TIMEOUT;
        end else if (accept && (state_q == ST_IDLE) && (byte_data_i[7:5] != SYNC)) begin
            err_set   = 1'b1;
            err_cause = ERR_SYNC;
        end
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        else if (accept && (state_q == ST_CHECK) && (byte_data_i != csum_q)) begin
            err_set   = 1'b1;
            err_cause = ERR_CHECKSUM;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= ST_IDLE;
            type_q      <= 3'd0;
            data_lo_q   <= 8'd0;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
            data_hi_q   <= 8'd0;
            csum_q      <= 8'd0;
`endif
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= 3'd0;
            cmd_data_q  <= 16'd0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_cnt_q   <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            frame_err_q <= err_set;
            if (err_set) begin
                err_code_q <= err_cause;
                if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                end
            end

            if (tmo_hit) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept && !err_set) begin
                            type_q    <= byte_data_i[2:0];
                            data_lo_q <= 8'd0;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
                            data_hi_q <= 8'd0;
                            csum_q    <= byte_data_i;
`endif
                            if (has_payload(byte_data_i[2:0])) begin
                                state_q <= ST_DATA_LO;
                            end else begin
`ifdef TRAFFIC_CMD_CHECKSUM_EN
                                state_q <= ST_CHECK;
`else
                                state_q     <= ST_EMIT;
                                cmd_valid_q <= 1'b1;
                                cmd_type_q  <= byte_data_i[2:0];
                                cmd_data_q  <= 16'd0;
`endif
                            end
                        end
                    end
                    ST_DATA_LO: begin
                        if (accept) begin
                            data_lo_q <= byte_data_i;
`ifdef TRAFFIC_CMD_CHECKSUM_EN
                            csum_q    <= csum_q ^ byte_data_i;
`endif
                            state_q   <= ST_DATA_HI;
                        end
                    end
                    ST_DATA_HI: begin
                        if (accept) begin
`ifdef TRAFFIC_CMD_CHECKSUM_EN
                            data_hi_q <= byte_data_i;
                            csum_q    <= csum_q ^ byte_data_i;
                            state_q   <= ST_CHECK;
`else
                            state_q     <= ST_EMIT;
                            cmd_valid_q <= 1'b1;
                            cmd_type_q  <= type_q;
                            cmd_data_q  <= {byte_data_i, data_lo_q};
`endif
                        end
                    end
`ifdef TRAFFIC_CMD_CHECKSUM_EN
                    ST_CHECK: begin
                        if (accept) begin
                            state_q <= ST_IDLE;
                            if (!err_set) begin
                                state_q     <= ST_EMIT;
                                cmd_valid_q <= 1'b1;
                                cmd_type_q  <= type_q;
                                cmd_data_q  <= {data_hi_q, data_lo_q};
                            end
                        end
                    end
`endif
                    ST_EMIT: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_type_o  = cmd_type_q;
    assign cmd_data_o  = cmd_data_q;
    assign frame_err_o = frame_err_q;
    assign err_code_o  = err_code_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_traffic_cmd_assembler.sv
// Bench for traffic_cmd_assembler: directed frames, timeout boundary, async
// reset, counter saturation and randomized streams against a frame-level model.
`timescale 1ns/1ps
module tb_traffic_cmd_assembler;

    localparam int TMO = 20;
    localparam int ECW = 2;
    localparam int EVW = 21;

    logic           clk = 1'b0;
    logic           arst_n = 1'b0;
    logic [7:0]     byte_data = 8'h00;
    logic           byte_valid = 1'b0;
    logic           byte_ready;
    logic [2:0]     cmd_type;
    logic [15:0]    cmd_data;
    logic           cmd_valid;
    logic           frame_err;
    logic [1:0]     err_code;
    logic [ECW-1:0] err_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // Events: {2'b01, type, data} for a command, {2'b10, 17'd0, code} for an error.
    logic [EVW-1:0] exp_q[$];
    logic [EVW-1:0] got_q[$];
    logic [7:0]     stim_q[$];
    bit             mon_en = 1'b0;
    int             ready_low_cnt = 0;
    int             excl_viol = 0;
    int             model_errs = 0;
    logic [1:0]     model_code = 2'd0;
    int             model_cmds = 0;

    traffic_cmd_assembler #(
        .TIMEOUT_CLK(TMO),
        .ERR_CNT_W  (ECW)
    ) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .byte_data_i (byte_data),
        .byte_valid_i(byte_valid),
        .byte_ready_o(byte_ready),
        .cmd_type_o  (cmd_type),
        .cmd_data_o  (cmd_data),
        .cmd_valid_o (cmd_valid),
        .frame_err_o (frame_err),
        .err_code_o  (err_code),
        .err_cnt_o   (err_cnt)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        if (cmd_valid === 1'b1 && frame_err === 1'b1) excl_viol++;
        if (mon_en) begin
            if (cmd_valid === 1'b1) got_q.push_back({2'b01, cmd_type, cmd_data});
            if (frame_err === 1'b1) got_q.push_back({2'b10, 17'd0, err_code});
            if (byte_ready !== 1'b1) ready_low_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t required below 500000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [ECW-1:0] exp_cnt(input int n);
        if (n >= (1 << ECW) - 1) return '1;
        return ECW'(n);
    endfunction

    task automatic do_reset();
        byte_valid = 1'b0;
        arst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;
        model_errs = 0;
        model_code = 2'd0;
        model_cmds = 0;
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Presents one byte and returns #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int stall;
        stall = 0;
        byte_data = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && stall < 50) begin
            @(posedge clk); #1;
            stall++;
        end
        if (byte_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_byte_stall: byte_ready=%b required 1", byte_ready);
        end else begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
    endtask

    task automatic push_frame(input logic [2:0] t, input logic [15:0] d);
        logic [7:0] hdr;
        logic [7:0] x;
        bit         pay;
        hdr = {3'b101, 2'($urandom_range(0, 3)), t};
        pay = (t >= 3'd3) && (t <= 3'd5);
        x = hdr;
        stim_q.push_back(hdr);
        if (pay) begin
            stim_q.push_back(d[7:0]);
            stim_q.push_back(d[15:8]);
            x = x ^ d[7:0] ^ d[15:8];
        end
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        stim_q.push_back(x);
`endif
        exp_q.push_back({2'b01, t, pay ? d : 16'h0000});
        model_cmds++;
    endtask

`ifdef TRAFFIC_CMD_CHECKSUM_EN
    task automatic push_bad_csum(input logic [2:0] t, input logic [15:0] d);
        logic [7:0] hdr;
        logic [7:0] x;
        hdr = {3'b101, 2'($urandom_range(0, 3)), t};
        x = hdr;
        stim_q.push_back(hdr);
        if ((t >= 3'd3) && (t <= 3'd5)) begin
            stim_q.push_back(d[7:0]);
            stim_q.push_back(d[15:8]);
            x = x ^ d[7:0] ^ d[15:8];
        end
        stim_q.push_back(x ^ 8'($urandom_range(1, 255)));
        exp_q.push_back({2'b10, 17'd0, 2'd3});
        model_errs++;
        model_code = 2'd3;
    endtask
`endif

    task automatic push_bad_sync();
        int s;
        s = $urandom_range(0, 6);
        if (s >= 5) s++;
        stim_q.push_back({3'(s), 5'($urandom_range(0, 31))});
        exp_q.push_back({2'b10, 17'd0, 2'd1});
        model_errs++;
        model_code = 2'd1;
    endtask

    task automatic test_reset();
        byte_valid = 1'b0;
        arst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({byte_ready, cmd_valid, cmd_type, cmd_data, frame_err, err_code, err_cnt} !==
            {1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 2'd0, {ECW{1'b0}}}) begin
            tests_failed++;
            $display("FAIL reset_values: rdy/vld/type/data/err/code/cnt=%b/%b/%h/%h/%b/%h/%h required 1/0/0/0000/0/0/0",
                     byte_ready, cmd_valid, cmd_type, cmd_data, frame_err, err_code, err_cnt);
        end
        arst_n = 1'b1;
        idle(2);
        tests_run++;
        if ({byte_ready, cmd_valid, frame_err, err_cnt} !== {1'b1, 1'b0, 1'b0, {ECW{1'b0}}}) begin
            tests_failed++;
            $display("FAIL after_reset_idle: rdy/vld/err/cnt=%b/%b/%b/%h required 1/0/0/0",
                     byte_ready, cmd_valid, frame_err, err_cnt);
        end
    endtask

    task automatic test_frames();
        do_reset();
        send_byte(8'hA4); send_byte(8'hE8); send_byte(8'h03);
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        send_byte(8'h4F);
`endif
        tests_run++;
        if ({cmd_valid, cmd_type, cmd_data, frame_err} !== {1'b1, 3'd4, 16'h03E8, 1'b0}) begin
            tests_failed++;
            $display("FAIL set_r_frame: vld/type/data/err=%b/%h/%h/%b required 1/4/03e8/0",
                     cmd_valid, cmd_type, cmd_data, frame_err);
        end
        send_byte(8'hA1);
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        send_byte(8'hA1);
`endif
        tests_run++;
        if ({cmd_valid, cmd_type, cmd_data} !== {1'b1, 3'd1, 16'h0000}) begin
            tests_failed++;
            $display("FAIL off_frame: vld/type/data=%b/%h/%h required 1/1/0000", cmd_valid, cmd_type, cmd_data);
        end
        idle(1);
        tests_run++;
        if ({cmd_valid, cmd_type} !== {1'b0, 3'd1}) begin
            tests_failed++;
            $display("FAIL strobe_width: vld/type=%b/%h required 0/1", cmd_valid, cmd_type);
        end
        send_byte(8'h21);
        tests_run++;
        if ({frame_err, err_code, err_cnt, cmd_valid} !== {1'b1, 2'd1, exp_cnt(1), 1'b0}) begin
            tests_failed++;
            $display("FAIL bad_sync: err/code/cnt/vld=%b/%h/%h/%b required 1/1/%h/0",
                     frame_err, err_code, err_cnt, cmd_valid, exp_cnt(1));
        end
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        send_byte(8'hA3); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
        tests_run++;
        if ({frame_err, err_code, err_cnt, cmd_valid} !== {1'b1, 2'd3, exp_cnt(2), 1'b0}) begin
            tests_failed++;
            $display("FAIL bad_checksum: err/code/cnt/vld=%b/%h/%h/%b required 1/3/%h/0",
                     frame_err, err_code, err_cnt, cmd_valid, exp_cnt(2));
        end
        send_byte(8'hA0); send_byte(8'hA0);
`else
        send_byte(8'hA3); send_byte(8'h10); send_byte(8'h00);
        tests_run++;
        if ({cmd_valid, cmd_type, cmd_data, frame_err} !== {1'b1, 3'd3, 16'h0010, 1'b0}) begin
            tests_failed++;
            $display("FAIL set_g_frame: vld/type/data/err=%b/%h/%h/%b required 1/3/0010/0",
                     cmd_valid, cmd_type, cmd_data, frame_err);
        end
        send_byte(8'hA0);
`endif
        tests_run++;
        if ({cmd_valid, cmd_type, cmd_data, frame_err} !== {1'b1, 3'd0, 16'h0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL run_frame: vld/type/data/err=%b/%h/%h/%b required 1/0/0000/0",
                     cmd_valid, cmd_type, cmd_data, frame_err);
        end
    endtask

    task automatic test_timeout();
        bit early;
        do_reset();
        send_byte(8'hA5);
        early = 1'b0;
        repeat (TMO - 1) begin
            @(posedge clk); #1;
            if (frame_err !== 1'b0) early = 1'b1;
        end
        tests_run++;
        if (early) begin
            tests_failed++;
            $display("FAIL timeout_early: frame_err seen 1 within %0d idle cycles required 0", TMO - 1);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({frame_err, err_code, err_cnt, cmd_valid} !== {1'b1, 2'd2, exp_cnt(1), 1'b0}) begin
            tests_failed++;
            $display("FAIL timeout_fire: err/code/cnt/vld=%b/%h/%h/%b required 1/2/%h/0",
                     frame_err, err_code, err_cnt, cmd_valid, exp_cnt(1));
        end
        send_byte(8'hA1);
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        send_byte(8'hA1);
`endif
        tests_run++;
        if ({cmd_valid, cmd_type} !== {1'b1, 3'd1}) begin
            tests_failed++;
            $display("FAIL after_timeout_idle: vld/type=%b/%h required 1/1", cmd_valid, cmd_type);
        end
        send_byte(8'hA5);
        idle(TMO - 1);
        send_byte(8'h34);
        tests_run++;
        if (frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_byte_wins: frame_err=%b required 0", frame_err);
        end
        send_byte(8'h12);
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        send_byte(8'h83);
`endif
        tests_run++;
        if ({cmd_valid, cmd_type, cmd_data, err_cnt} !== {1'b1, 3'd5, 16'h1234, exp_cnt(1)}) begin
            tests_failed++;
            $display("FAIL late_byte_frame: vld/type/data/cnt=%b/%h/%h/%h required 1/5/1234/%h",
                     cmd_valid, cmd_type, cmd_data, err_cnt, exp_cnt(1));
        end
    endtask

    task automatic test_async_reset();
        send_byte(8'hA4);
        #2;
        arst_n = 1'b0;
        #1;
        tests_run++;
        if ({byte_ready, cmd_valid, cmd_type, cmd_data, frame_err, err_code, err_cnt} !==
            {1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 2'd0, {ECW{1'b0}}}) begin
            tests_failed++;
            $display("FAIL async_reset: rdy/vld/type/data/err/code/cnt=%b/%b/%h/%h/%b/%h/%h required 1/0/0/0000/0/0/0",
                     byte_ready, cmd_valid, cmd_type, cmd_data, frame_err, err_code, err_cnt);
        end
        #2;
        arst_n = 1'b1;
        @(posedge clk); #1;
        send_byte(8'hA4); send_byte(8'hE8); send_byte(8'h03);
`ifdef TRAFFIC_CMD_CHECKSUM_EN
        send_byte(8'h4F);
`endif
        tests_run++;
        if ({cmd_valid, cmd_type, cmd_data, frame_err, err_cnt} !== {1'b1, 3'd4, 16'h03E8, 1'b0, {ECW{1'b0}}}) begin
            tests_failed++;
            $display("FAIL frame_after_reset: vld/type/data/err/cnt=%b/%h/%h/%b/%h required 1/4/03e8/0/0",
                     cmd_valid, cmd_type, cmd_data, frame_err, err_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] bad [5];
        bad = '{8'h21, 8'hFF, 8'h00, 8'h7A, 8'hC5};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_byte(bad[i]);
            tests_run++;
            if ({frame_err, err_code, err_cnt} !== {1'b1, 2'd1, exp_cnt(i + 1)}) begin
                tests_failed++;
                $display("FAIL saturation_%0d: err/code/cnt=%b/%h/%h required 1/1/%h",
                         i, frame_err, err_code, err_cnt, exp_cnt(i + 1));
            end
        end
    endtask

    task automatic test_stream(input string label, input int n_items, input int gap_max);
        int k;
        do_reset();
        exp_q.delete();
        got_q.delete();
        stim_q.delete();
        ready_low_cnt = 0;
        for (int i = 0; i < n_items; i++) begin
            k = $urandom_range(0, 9);
            if (k < 2) push_bad_sync();
`ifdef TRAFFIC_CMD_CHECKSUM_EN
            else if (k < 4) push_bad_csum(3'($urandom_range(0, 7)), 16'($urandom));
`endif
            else push_frame(3'($urandom_range(0, 7)), 16'($urandom));
        end
        mon_en = 1'b1;
        while (stim_q.size() > 0) begin
            send_byte(stim_q.pop_front());
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
        idle(4);
        mon_en = 1'b0;
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s_event_count: got %0d events required %0d", label, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s_event_%0d: got %h required %h", label, i, got_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (ready_low_cnt != model_cmds) begin
            tests_failed++;
            $display("FAIL %s_ready_low: got %0d stall cycles required %0d", label, ready_low_cnt, model_cmds);
        end
        tests_run++;
        if (err_cnt !== exp_cnt(model_errs)) begin
            tests_failed++;
            $display("FAIL %s_err_cnt: got %h required %h", label, err_cnt, exp_cnt(model_errs));
        end
        if (model_errs > 0) begin
            tests_run++;
            if (err_code !== model_code) begin
                tests_failed++;
                $display("FAIL %s_err_code: got %h required %h", label, err_code, model_code);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_timeout();
        test_async_reset();
        test_saturation();
        test_stream("random", 40, 3);
        test_stream("back_to_back", 16, 0);
        tests_run++;
        if (excl_viol != 0) begin
            tests_failed++;
            $display("FAIL strobe_exclusive: got %0d overlapping cycles required 0", excl_viol);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
